// File: rtl/ws2812_px_serializer.sv
// WS2812 / NeoPixel single-wire serializer.
// Accepts one NUM_BITS-wide pixel word over a valid/ready handshake and shifts it out MSB first.
// Each bit lasts BIT_CYC clocks: high for T1H_CYC ('1') or T0H_CYC ('0') clocks, then low.
// The frame latch is left to the upstream, which keeps the line idle long enough.
// Optional build macro WS2812_INVERT_OUT_EN: o_serial is inverted, so reset and idle are high,
// for inverting level shifters. Handshake and timing do not change.

module ws2812_px_serializer #(
  parameter int unsigned CLK_HZ   = 72000000,
  parameter int unsigned T0H_CYC  = 29,
  parameter int unsigned T1H_CYC  = 58,
  parameter int unsigned BIT_CYC  = 90,
  parameter int unsigned NUM_BITS = 24
) (
  input  logic                axis_aclk,
  input  logic                axis_reset,
  input  logic [NUM_BITS-1:0] s_axis_data,
  input  logic                s_axis_valid,
  output logic                s_axis_ready,
  output logic                o_serial
);

  localparam int unsigned CycW = $clog2(BIT_CYC);
  localparam int unsigned BitW = $clog2(NUM_BITS + 1);

  localparam logic [CycW-1:0] T0hCyc   = CycW'(T0H_CYC);
  localparam logic [CycW-1:0] T1hCyc   = CycW'(T1H_CYC);
  localparam logic [CycW-1:0] CycLast  = CycW'(BIT_CYC - 1);
  localparam logic [BitW-1:0] BitsDone = BitW'(NUM_BITS);

`ifdef WS2812_INVERT_OUT_EN
  localparam logic InvOut = 1'b1;
`else
  localparam logic InvOut = 1'b0;
`endif

  // Reject bit timings that cannot produce a valid waveform.
  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && CLK_HZ > 0)) begin : g_cfg_check
    $error("ws2812_px_serializer: illegal bit timing configuration");
  end

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [CycW-1:0]     cyc_q, cyc_d;
  logic                ready_q, ready_d;
  logic                ser_q;
  logic                ser_d;

  // Next-state logic. In StSend the counters name the bit slot being driven from this edge on;
  // bit_q == NUM_BITS means the last low phase has just ended.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    ready_d = ready_q;
    ser_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // ready_q is still low on the first edge after reset, so no transfer happens there.
        ready_d = 1'b1;
        if (s_axis_valid && ready_q) begin
          state_d = StSend;
          shreg_d = s_axis_data;
          bit_d   = '0;
          cyc_d   = '0;
          ready_d = 1'b0;
        end
      end
      StSend: begin
        ready_d = 1'b0;
        if (bit_q == BitsDone) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          ser_d = (cyc_q < (shreg_q[NUM_BITS-1] ? T1hCyc : T0hCyc));
          if (cyc_q == CycLast) begin
            cyc_d   = '0;
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[NUM_BITS-2:0], 1'b0};
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and output registers. Reset aborts any word in flight.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      ready_q <= 1'b0;
      ser_q   <= InvOut;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      ser_q   <= ser_d ^ InvOut;
    end
  end

  assign s_axis_ready = ready_q;
  assign o_serial     = ser_q;

endmodule

// File: tb/tb_ws2812_px_serializer.sv
// Directed bench for ws2812_px_serializer.
// All samples are taken 1 time unit after a rising edge. Inputs are driven at those points too.

module tb_ws2812_px_serializer;

  localparam int T0H      = 29;
  localparam int T1H      = 58;
  localparam int BITC     = 90;
  localparam int NB       = 24;
  localparam int WORD_CYC = NB * BITC;

`ifdef WS2812_INVERT_OUT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        axis_aclk    = 1'b0;
  logic        axis_reset   = 1'b1;
  logic [23:0] s_axis_data  = '0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic        o_serial;
  logic        line;

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] b2b_words [8] = '{24'h000000, 24'hFFFFFF, 24'h123456, 24'h800001,
                                 24'hA5A5A5, 24'h0F0F0F, 24'h7FFFFE, 24'hC0FFEE};

  // Logical waveform, independent of the output polarity build option.
  assign line = o_serial ^ INV;

  ws2812_px_serializer dut (
    .axis_aclk    (axis_aclk),
    .axis_reset   (axis_reset),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .o_serial     (o_serial)
  );

  always #5 axis_aclk = ~axis_aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called 1 unit after an edge with ready high. The next edge is the transfer edge k.
  task automatic handshake(input logic [23:0] d);
    s_axis_data  = d;
    s_axis_valid = 1'b1;
    @(posedge axis_aclk);
    #1;
    chk("hs_ready_low", {31'd0, s_axis_ready}, 0);
    chk("hs_line_low", {31'd0, line}, 0);
  endtask

  // Samples the 2160 bit cycles after edges k+1..k+2160, then the completion edge k+2161.
  // If pulse_at >= 0, valid is pulsed with 24'hFFFFFF for one edge during the word.
  task automatic body(input logic [23:0] d, input bit keep_valid, input int pulse_at);
    int hi [NB];
    int shape_err;
    int rdy_err;
    int n;
    int j;
    int th;
    for (int b = 0; b < NB; b++) hi[b] = 0;
    shape_err = 0;
    rdy_err   = 0;
    if (!keep_valid) s_axis_valid = 1'b0;
    for (int i = 0; i < WORD_CYC; i++) begin
      @(posedge axis_aclk);
      #1;
      n  = i / BITC;
      j  = i % BITC;
      th = d[NB-1-n] ? T1H : T0H;
      if (line === 1'b1) hi[n]++;
      if (line !== (j < th)) shape_err++;
      if (s_axis_ready !== 1'b0) rdy_err++;
      if (i == pulse_at) begin
        s_axis_valid = 1'b1;
        s_axis_data  = 24'hFFFFFF;
      end else if (i == pulse_at + 1) begin
        s_axis_valid = 1'b0;
      end
    end
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("w%06h_bit%0d_high", d, NB - 1 - b), hi[b], d[NB-1-b] ? T1H : T0H);
    end
    chk($sformatf("w%06h_shape", d), shape_err, 0);
    chk($sformatf("w%06h_ready_busy", d), rdy_err, 0);
    @(posedge axis_aclk);
    #1;
    chk($sformatf("w%06h_done_ready", d), {31'd0, s_axis_ready}, 1);
    chk($sformatf("w%06h_done_line", d), {31'd0, line}, 0);
  endtask

  // Line must stay idle (ready high, line low) for ncyc edges.
  task automatic idle_check(input string tag, input int ncyc);
    int err;
    err = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge axis_aclk);
      #1;
      if (s_axis_ready !== 1'b1 || line !== 1'b0) err++;
    end
    chk(tag, err, 0);
  endtask

  initial begin
    // Reset values while reset is held from time zero.
    #1;
    chk("rst_ready", {31'd0, s_axis_ready}, 0);
    chk("rst_line", {31'd0, line}, 0);

    // Release mid-cycle: ready stays low until the next edge.
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    #1;
    chk("rel_ready_pre_edge", {31'd0, s_axis_ready}, 0);
    @(posedge axis_aclk);
    #1;
    chk("rel_ready_post_edge", {31'd0, s_axis_ready}, 1);
    chk("rel_line", {31'd0, line}, 0);

    // Mid-cycle reset while idle drops ready at once.
    repeat (3) @(posedge axis_aclk);
    #3;
    axis_reset = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, s_axis_ready}, 0);
    chk("async_rst_line", {31'd0, line}, 0);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    @(posedge axis_aclk);
    #1;
    chk("async_rel_ready", {31'd0, s_axis_ready}, 1);

    // Single words.
    handshake(24'h800000);
    body(24'h800000, 1'b0, -1);
    idle_check("idle_after_800000", 50);

    handshake(24'h00FF00);
    body(24'h00FF00, 1'b0, -1);
    idle_check("idle_after_00ff00", 50);

    // Valid pulsed mid-word is ignored and no second word follows.
    handshake(24'h5A0F3C);
    body(24'h5A0F3C, 1'b0, 1000);
    idle_check("no_extra_word", 300);

    // Back-to-back: valid stays high. Ready returns at the completion edge, the next transfer
    // is on the following edge, and its first high one edge after that.
    for (int w = 0; w < 8; w++) begin
      handshake(b2b_words[w]);
      body(b2b_words[w], 1'b1, -1);
    end
    s_axis_valid = 1'b0;
    idle_check("idle_after_b2b", 300);

    // Reset during bit 10 of 24'hAAAAAA (a '1' bit, line high at that point).
    handshake(24'hAAAAAA);
    s_axis_valid = 1'b0;
    repeat (10 * BITC + 20) @(posedge axis_aclk);
    #2;
    chk("pre_abort_line_high", {31'd0, line}, 1);
    axis_reset = 1'b1;
    #1;
    chk("abort_line", {31'd0, line}, 0);
    chk("abort_ready", {31'd0, s_axis_ready}, 0);
    repeat (3) @(posedge axis_aclk);
    #1;
    chk("abort_hold_line", {31'd0, line}, 0);
    @(negedge axis_aclk);
    axis_reset = 1'b0;
    @(posedge axis_aclk);
    #1;
    chk("abort_rel_ready", {31'd0, s_axis_ready}, 1);
    handshake(24'h000001);
    body(24'h000001, 1'b0, -1);
    idle_check("idle_final", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
